clock_div_bank: RTL and testbench

CLOCK_DIV_BANK -- requirements
Module: clock_div_bank

---
 rtl/clock_div_bank.sv | 181 ++++++++++++++++++
 tb/tb_clock_div_bank.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_bank.sv
// clock_div_bank: a bank of CHANNELS independent programmable clock dividers.
// Each channel counts 0..P and drives a registered divided clock (high while
// cnt < H) plus a one-cycle tick at the start of every period. New P/H values
// are written through a shadow register and take effect only at a period
// boundary, so a period never mixes old and new settings.
// Optional feature: define CLKDIV_SYNC_EN to make the sync input realign all
// running channels; without it the sync input is accepted but ignored.
module clock_div_bank #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 9,
    parameter int DEFAULT_HIGH   = 5,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [WIDTH-1:0]    cfg_high,
    input  logic                sync,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] DEF_P  = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] DEF_H  = WIDTH'(DEFAULT_HIGH);

    logic [CHANNELS-1:0] pend_vec_s;
    logic                sync_s;

`ifdef CLKDIV_SYNC_EN
    assign sync_s = sync;
`else
    logic unused_sync_s;
    assign unused_sync_s = sync;
    assign sync_s        = 1'b0;
`endif

    // Configuration handshake: ready only for an in-range channel with no update waiting
    always_comb begin
        if (32'(cfg_ch) < 32'(CHANNELS)) begin
            cfg_ready = ~pend_vec_s[cfg_ch];
        end else begin
            cfg_ready = 1'b0;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           state_r;
        state_t           state_s;
        logic [WIDTH-1:0] cnt_r;
        logic [WIDTH-1:0] cnt_s;
        logic [WIDTH-1:0] per_r;
        logic [WIDTH-1:0] per_s;
        logic [WIDTH-1:0] high_r;
        logic [WIDTH-1:0] high_s;
        logic [WIDTH-1:0] sh_per_r;
        logic [WIDTH-1:0] sh_per_s;
        logic [WIDTH-1:0] sh_high_r;
        logic [WIDTH-1:0] sh_high_s;
        logic             pend_r;
        logic             pend_s;
        logic             take_s;
        logic             apply_s;
        logic             tick_r;
        logic             tick_s;
        logic             clk_r;
        logic             clk_s;

        assign take_s        = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));
        assign pend_vec_s[g] = pend_r;
        assign tick[g]       = tick_r;
        assign clk_out[g]    = clk_r;

        // Next-state: counter sequencing, boundary-aligned shadow apply, shadow capture
        always_comb begin
            state_s   = state_r;
            cnt_s     = cnt_r;
            per_s     = per_r;
            high_s    = high_r;
            sh_per_s  = sh_per_r;
            sh_high_s = sh_high_r;
            pend_s    = pend_r;
            apply_s   = 1'b0;

            case (state_r)
                ST_IDLE: begin
                    // An idle channel has no period in flight, so an update lands at once
                    apply_s = pend_r;
                    cnt_s   = ZERO_W;
                    if (en[g]) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    apply_s = pend_r & ((cnt_r == per_r) | sync_s);
                    if (!en[g]) begin
                        state_s = ST_IDLE;
                        cnt_s   = ZERO_W;
                    end else if ((cnt_r == per_r) || sync_s) begin
                        state_s = ST_RUN;
                        cnt_s   = ZERO_W;
                    end else begin
                        state_s = ST_RUN;
                        cnt_s   = cnt_r + ONE_W;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = ZERO_W;
                end
            endcase

            if (apply_s) begin
                per_s  = sh_per_r;
                high_s = sh_high_r;
                pend_s = 1'b0;
            end else begin
                per_s  = per_r;
                high_s = high_r;
            end

            // take_s needs pend_r low and apply_s needs it high, so they never collide
            if (take_s) begin
                sh_per_s  = cfg_period;
                sh_high_s = cfg_high;
                pend_s    = 1'b1;
            end else begin
                sh_per_s  = sh_per_r;
                sh_high_s = sh_high_r;
            end

            // Outputs are derived from next-cycle values so they register in step with cnt
            if (state_s == ST_RUN) begin
                tick_s = (cnt_s == ZERO_W);
                clk_s  = (cnt_s < high_s);
            end else begin
                tick_s = 1'b0;
                clk_s  = 1'b0;
            end
        end

        // Channel state and registered outputs, async-cleared to defaults
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r   <= ST_IDLE;
                cnt_r     <= ZERO_W;
                per_r     <= DEF_P;
                high_r    <= DEF_H;
                sh_per_r  <= DEF_P;
                sh_high_r <= DEF_H;
                pend_r    <= 1'b0;
                tick_r    <= 1'b0;
                clk_r     <= 1'b0;
            end else begin
                state_r   <= state_s;
                cnt_r     <= cnt_s;
                per_r     <= per_s;
                high_r    <= high_s;
                sh_per_r  <= sh_per_s;
                sh_high_r <= sh_high_s;
                pend_r    <= pend_s;
                tick_r    <= tick_s;
                clk_r     <= clk_s;
            end
        end
    end

endmodule

// File: tb/tb_clock_div_bank.sv
// Testbench for clock_div_bank: directed scenarios plus randomized traffic,
// checked against a phase-based behavioural model of each channel.
module tb_clock_div_bank;
    localparam int CH = 4;
`ifdef CLKDIV_SYNC_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [15:0]   cfg_period;
    logic [15:0]   cfg_high;
    logic          sync;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: running flag, phase within the period, active/shadow settings, pending
    int m_run[CH];
    int m_ph[CH];
    int m_p[CH];
    int m_h[CH];
    int m_sp[CH];
    int m_sh[CH];
    int m_pend[CH];

    clock_div_bank dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high), .sync(sync),
        .clk_out(clk_out), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 0; m_ph[i] = 0; m_p[i] = 9; m_h[i] = 5;
            m_sp[i] = 9; m_sh[i] = 5; m_pend[i] = 0;
        end
    endfunction

    // One rising edge of the model, using the inputs the DUT will sample
    function automatic void model_edge();
        bit take;
        bit do_sync;
        bit apply;
        take    = cfg_valid && (m_pend[cfg_ch] == 0);
        do_sync = SYNC_ON && sync;
        for (int i = 0; i < CH; i++) begin
            apply = (m_pend[i] != 0) &&
                    ((m_run[i] == 0) || (m_ph[i] == m_p[i]) || (do_sync && m_run[i] != 0));
            if (en[i]) begin
                if (m_run[i] != 0 && !do_sync) m_ph[i] = (m_ph[i] + 1) % (m_p[i] + 1);
                else m_ph[i] = 0;
                m_run[i] = 1;
            end else begin
                m_run[i] = 0;
                m_ph[i]  = 0;
            end
            if (apply) begin
                m_p[i] = m_sp[i]; m_h[i] = m_sh[i]; m_pend[i] = 0;
            end
            if (take && int'(cfg_ch) == i) begin
                m_sp[i] = int'(cfg_period); m_sh[i] = int'(cfg_high); m_pend[i] = 1;
            end
        end
    endfunction

    function automatic logic [CH-1:0] exp_tick();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = (m_run[i] != 0) && (m_ph[i] == 0);
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_clk();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = (m_run[i] != 0) && (m_ph[i] < m_h[i]);
        return r;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Hold a configuration request until the channel accepts it
    task automatic cfg_write(input int ch, input int p, input int h);
        bit accepted;
        accepted   = 1'b0;
        cfg_ch     = 2'(ch);
        cfg_period = 16'(p);
        cfg_high   = 16'(h);
        cfg_valid  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            accepted = (m_pend[ch] == 0);
            step();
            if (accepted) break;
        end
        cfg_valid = 1'b0;
        if (!accepted) begin
            n_fail++;
            $display("FAIL cfg_write_timeout ch%0d: request never accepted within 100 cycles", ch);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = 2'd0;
        cfg_period = 16'd0; cfg_high = 16'd0; sync = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (tick !== 4'b0000 || clk_out !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: tick=%b clk_out=%b, expected 0000/0000", tick, clk_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < CH; c++) begin
            cfg_ch = 2'(c);
            #1;
            n_checks++;
            if (cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready ch%0d: cfg_ready=%b, expected 1", c, cfg_ready);
            end
        end
        cfg_ch = 2'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (tick !== 4'b0000 || clk_out !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_outputs: tick=%b clk_out=%b, expected 0000/0000", tick, clk_out);
            end
        end
    endtask

    task automatic test_default_div();
        int ticks;
        int highs;
        ticks = 0; highs = 0;
        en = 4'b0001;
        for (int k = 0; k < 30; k++) begin
            step();
            n_checks++;
            if (tick !== exp_tick() || clk_out !== exp_clk()) begin
                n_fail++;
                $display("FAIL default_div cyc%0d: tick=%b clk_out=%b, expected %b/%b",
                         k, tick, clk_out, exp_tick(), exp_clk());
            end
            if (tick[0]) ticks++;
            if (clk_out[0]) highs++;
        end
        n_checks++;
        if (ticks != 3 || highs != 15) begin
            n_fail++;
            $display("FAIL default_div_counts: ticks=%0d highs=%0d, expected 3/15", ticks, highs);
        end
    endtask

    task automatic test_reconfig();
        int ticks;
        int highs;
        logic exp_r;
        ticks = 0; highs = 0;
        repeat (3) step();
        cfg_ch = 2'd0; cfg_period = 16'd3; cfg_high = 16'd1; cfg_valid = 1'b1;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reconfig_ready_before: cfg_ready=%b, expected 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            exp_r = (m_pend[0] == 0);
            n_checks++;
            if (cfg_ready !== exp_r) begin
                n_fail++;
                $display("FAIL reconfig_ready k%0d: cfg_ready=%b, expected %b", k, cfg_ready, exp_r);
            end
            step();
            n_checks++;
            if (tick !== exp_tick() || clk_out !== exp_clk()) begin
                n_fail++;
                $display("FAIL reconfig k%0d: tick=%b clk_out=%b, expected %b/%b",
                         k, tick, clk_out, exp_tick(), exp_clk());
            end
            if (k == 7) begin
                n_checks++;
                if (tick[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reconfig_first_new_tick: tick0=%b, expected 1", tick[0]);
                end
            end
            if (k >= 8) begin
                if (tick[0]) ticks++;
                if (clk_out[0]) highs++;
            end
        end
        n_checks++;
        if (ticks != 2 || highs != 2) begin
            n_fail++;
            $display("FAIL reconfig_new_period: ticks=%0d highs=%0d, expected 2/2", ticks, highs);
        end
    endtask

    task automatic test_p_zero();
        en = 4'b0011;
        cfg_write(1, 0, 1);
        for (int k = 0; k < 15; k++) begin
            step();
            n_checks++;
            if (tick !== exp_tick() || clk_out !== exp_clk()) begin
                n_fail++;
                $display("FAIL p_zero k%0d: tick=%b clk_out=%b, expected %b/%b",
                         k, tick, clk_out, exp_tick(), exp_clk());
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (tick[1] !== 1'b1 || clk_out[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL p_zero_h1 k%0d: tick1=%b clk1=%b, expected 1/1", k, tick[1], clk_out[1]);
            end
        end
        cfg_write(1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (tick[1] !== 1'b1 || clk_out[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL p_zero_h0 k%0d: tick1=%b clk1=%b, expected 1/0", k, tick[1], clk_out[1]);
            end
        end
    endtask

    task automatic test_en_drop();
        en = 4'b0111;
        for (int k = 0; k < 20 && !(m_run[2] != 0 && m_ph[2] == 3); k++) begin
            step();
            n_checks++;
            if (tick !== exp_tick() || clk_out !== exp_clk()) begin
                n_fail++;
                $display("FAIL en_drop_run k%0d: tick=%b clk_out=%b, expected %b/%b",
                         k, tick, clk_out, exp_tick(), exp_clk());
            end
        end
        n_checks++;
        if (clk_out[2] !== 1'b1 || tick[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_at_cnt3: clk2=%b tick2=%b, expected 1/0", clk_out[2], tick[2]);
        end
        en[2] = 1'b0;
        step();
        n_checks++;
        if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_low: clk2=%b tick2=%b, expected 0/0", clk_out[2], tick[2]);
        end
        en[2] = 1'b1;
        step();
        n_checks++;
        if (tick[2] !== 1'b1 || clk_out[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL en_reenable: tick2=%b clk2=%b, expected 1/1", tick[2], clk_out[2]);
        end
        step();
        n_checks++;
        if (tick[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL en_restart_cnt1: tick2=%b, expected 0", tick[2]);
        end
    endtask

    task automatic test_sync();
        cfg_write(0, 9, 5);
        cfg_write(1, 6, 3);
        for (int k = 0; k < 60; k++) begin
            if (m_pend[0] == 0 && m_pend[1] == 0 && m_ph[0] != m_ph[1] &&
                m_ph[0] != 0 && m_ph[1] != 0 && m_ph[0] != 9 && m_ph[1] != 6) break;
            step();
            n_checks++;
            if (tick !== exp_tick() || clk_out !== exp_clk()) begin
                n_fail++;
                $display("FAIL sync_pre k%0d: tick=%b clk_out=%b, expected %b/%b",
                         k, tick, clk_out, exp_tick(), exp_clk());
            end
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        n_checks++;
        if (SYNC_ON && tick[1:0] !== 2'b11) begin
            n_fail++;
            $display("FAIL sync_align: tick[1:0]=%b, expected 11", tick[1:0]);
        end else if (!SYNC_ON && tick[1:0] === 2'b11) begin
            n_fail++;
            $display("FAIL sync_ignored: tick[1:0]=%b, expected not 11", tick[1:0]);
        end
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (tick !== exp_tick() || clk_out !== exp_clk()) begin
                n_fail++;
                $display("FAIL sync_post k%0d: tick=%b clk_out=%b, expected %b/%b",
                         k, tick, clk_out, exp_tick(), exp_clk());
            end
            step();
        end
    endtask

    task automatic test_random();
        logic exp_r;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(15, 0) == 0) en[i] = ~en[i];
            end
            cfg_valid  = ($urandom_range(3, 0) == 0);
            cfg_ch     = 2'($urandom_range(3, 0));
            cfg_period = 16'($urandom_range(12, 0));
            cfg_high   = 16'($urandom_range(14, 0));
            sync       = ($urandom_range(19, 0) == 0);
            #1;
            exp_r = (m_pend[cfg_ch] == 0);
            n_checks++;
            if (cfg_ready !== exp_r) begin
                n_fail++;
                $display("FAIL random_ready k%0d ch%0d: cfg_ready=%b, expected %b", k, cfg_ch, cfg_ready, exp_r);
            end
            step();
            n_checks++;
            if (tick !== exp_tick() || clk_out !== exp_clk()) begin
                n_fail++;
                $display("FAIL random k%0d: tick=%b clk_out=%b, expected %b/%b",
                         k, tick, clk_out, exp_tick(), exp_clk());
            end
        end
        cfg_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic test_async_reset();
        int ticks;
        int highs;
        ticks = 0; highs = 0;
        rst_n = 1'b0; en = 4'b0000;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        en = 4'b0001;
        step();
        step();
        cfg_write(0, 3, 1);
        cfg_ch = 2'd0;
        #1;
        n_checks++;
        if (clk_out[0] !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_pre: clk0=%b cfg_ready=%b, expected 1/0", clk_out[0], cfg_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_immediate: clk_out=%b tick=%b cfg_ready=%b, expected 0000/0000/1",
                     clk_out, tick, cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 22; k++) begin
            step();
            n_checks++;
            if (tick !== exp_tick() || clk_out !== exp_clk()) begin
                n_fail++;
                $display("FAIL areset_after k%0d: tick=%b clk_out=%b, expected %b/%b",
                         k, tick, clk_out, exp_tick(), exp_clk());
            end
            if (tick[0]) ticks++;
            if (clk_out[0]) highs++;
        end
        n_checks++;
        if (ticks != 3 || highs != 12) begin
            n_fail++;
            $display("FAIL areset_defaults: ticks=%0d highs=%0d, expected 3/12", ticks, highs);
        end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_reconfig();
        test_p_zero();
        test_en_drop();
        test_sync();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
